serial_shift_tx: RTL and testbench

Parallel-to-serial transmitter that drives a single-bit serial line.
It is the sending end for the team's flip-flop-based serial sampling and capture chain.
It accepts a WIDTH-bit word through a valid/ready handshake and sends it as a framed bit stream: start bit, data LSB first, then stop bit.
Each bit is held for CLK_DIV clock cycles.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_shift_tx_baud_tick_gen.sv | 32 +++
 rtl/serial_shift_tx.sv | 137 +++++++++++++
 tb/tb_serial_shift_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive pair: FSM state
// encoding, line levels and a counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/serial_shift_tx_baud_tick_gen.sv
// Bit-period divider: emits a one-cycle tick every CLK_DIV clocks,
// restarted from zero whenever clear is high.
module baud_tick_gen
  import serial_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 32'd1);

  logic [CW-1:0] r_cnt;

  // Divider counter; wraps at LAST so CLK_DIV=1 ticks every cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-to-serial framed transmitter: start bit, WIDTH data bits LSB
// first, stop bit, each held CLK_DIV clocks. All outputs are registered.
module serial_shift_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sd,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned   BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 32'd1);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [BW-1:0]    r_bit;
  logic [BW-1:0]    w_bit_next;
  logic             r_sd;
  logic             w_sd_next;
  logic             r_tx_ready;
  logic             r_busy;
  logic             r_frame_done;
  logic             w_done_next;
  logic             w_tick;
  logic             w_div_clear;

  // Holding the divider cleared while idle makes it start at zero on accept.
  assign w_div_clear = (r_state == IDLE);

  baud_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (w_div_clear),
    .tick  (w_tick)
  );

  // Next-state, shift register and bit index.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_state_next = START;
          w_shift_next = tx_data;
          w_bit_next   = '0;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_bit_next   = '0;
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit == LAST_BIT) begin
            w_state_next = STOP;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = STOP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, decoded from the next state so sd is a flop.
  always_comb begin
    w_sd_next = LINE_IDLE;
    case (w_state_next)
      IDLE:    w_sd_next = LINE_IDLE;
      START:   w_sd_next = START_BIT;
      DATA:    w_sd_next = w_shift_next[0];
      STOP:    w_sd_next = STOP_BIT;
      default: w_sd_next = LINE_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit        <= '0;
      r_sd         <= LINE_IDLE;
      r_tx_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit        <= w_bit_next;
      r_sd         <= w_sd_next;
      r_tx_ready   <= (w_state_next == IDLE);
      r_busy       <= (w_state_next != IDLE);
      r_frame_done <= w_done_next;
    end
  end

  assign tx_ready   = r_tx_ready;
  assign sd         = r_sd;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_shift_tx.sv
// Directed bench for serial_shift_tx: frame table plus reset/abort and
// CLK_DIV=1 sequences.
module tb_serial_shift_tx;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, sd, busy, frame_done;
  logic [7:0] tx_data1;
  logic       tx_valid1;
  logic       tx_ready1, sd1, busy1, frame_done1;

  int checks;
  int errors;

  serial_shift_tx #(.WIDTH(8), .CLK_DIV(DIV)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sd         (sd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  serial_shift_tx #(.WIDTH(8), .CLK_DIV(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data1),
    .tx_valid   (tx_valid1),
    .tx_ready   (tx_ready1),
    .sd         (sd1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // expected line levels, [0] = start bit
    bit         keep;  // hold tx_valid high through the frame
    int         poke;  // cycle at which to push an ignored word (0 = none)
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the frame_done cycle.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] seq, input bit keep, input int poke);
    check("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    for (int c = 1; c <= 10 * DIV; c++) begin
      @(negedge clk);
      if (c == 1 && !keep) tx_valid = 1'b0;
      if (poke != 0 && c == poke) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
      end
      check("sd_bit",     {31'd0, sd},         {31'd0, seq[(c - 1) / DIV]});
      check("ready_low",  {31'd0, tx_ready},   32'd0);
      check("busy_high",  {31'd0, busy},       32'd1);
      check("done_low",   {31'd0, frame_done}, 32'd0);
    end
    @(negedge clk);
    check("done_pulse",  {31'd0, frame_done}, 32'd1);
    check("done_ready",  {31'd0, tx_ready},   32'd1);
    check("done_idle_sd", {31'd0, sd},        32'd1);
    check("done_busy",   {31'd0, busy},       32'd0);
  endtask

  initial begin
    bit saw_done;
    bit saw_low;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 8'hA5;
    tx_valid1 = 1'b0;
    tx_data1  = 8'h00;

    vecs[0] = '{data: 8'hA5, seq: 10'b1_10100101_0, keep: 1'b0, poke: 0};
    vecs[1] = '{data: 8'h3C, seq: 10'b1_00111100_0, keep: 1'b1, poke: 0};
    vecs[2] = '{data: 8'hC3, seq: 10'b1_11000011_0, keep: 1'b0, poke: 0};
    vecs[3] = '{data: 8'hFF, seq: 10'b1_11111111_0, keep: 1'b0, poke: 10};

    // Reset held with tx_valid high: outputs idle, nothing starts.
    repeat (3) begin
      @(negedge clk);
      check("rst_sd",    {31'd0, sd},         32'd1);
      check("rst_ready", {31'd0, tx_ready},   32'd1);
      check("rst_busy",  {31'd0, busy},       32'd0);
      check("rst_done",  {31'd0, frame_done}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("first_accept_busy", {31'd0, busy},     32'd1);
    check("first_accept_sd",   {31'd0, sd},       32'd0);
    check("first_accept_rdy",  {31'd0, tx_ready}, 32'd0);
    reset    = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rerst_sd", {31'd0, sd}, 32'd1);

    // Frame table: plain, back-to-back pair, ignored mid-frame word.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].data, vecs[i].seq, vecs[i].keep, vecs[i].poke);
      if (!vecs[i].keep) begin
        tx_valid = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'd0, frame_done}, 32'd0);
        check("post_idle_sd",   {31'd0, sd},         32'd1);
        check("post_idle_busy", {31'd0, busy},       32'd0);
      end
    end

    // Reset at cycle 15 aborts the frame with no done pulse.
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
      check("abort_pre_sd", {31'd0, sd}, {31'd0, vecs[2].seq[(c - 1) / DIV]});
      if (c == 15) reset = 1'b1;
    end
    @(negedge clk);
    check("abort_sd",    {31'd0, sd},         32'd1);
    check("abort_ready", {31'd0, tx_ready},   32'd1);
    check("abort_busy",  {31'd0, busy},       32'd0);
    check("abort_done",  {31'd0, frame_done}, 32'd0);
    reset    = 1'b0;
    saw_done = 1'b0;
    saw_low  = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (frame_done) saw_done = 1'b1;
      if (!sd) saw_low = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_line_hi", {31'd0, saw_low},  32'd0);
    run_frame(8'h5A, 10'b1_01011010_0, 1'b0, 0);
    tx_valid = 1'b0;
    @(negedge clk);

    // CLK_DIV=1 instance, word 0x00.
    tx_valid1 = 1'b1;
    tx_data1  = 8'h00;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid1 = 1'b0;
      check("div1_sd",   {31'd0, sd1},          (c <= 9) ? 32'd0 : 32'd1);
      check("div1_done", {31'd0, frame_done1},  (c == 11) ? 32'd1 : 32'd0);
      check("div1_busy", {31'd0, busy1},        (c <= 10) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
